// File: rtl/grid_write_arbiter_pkg.sv
// Shared grid geometry, cell codes and arbiter state encoding for the grid write path.
package grid_write_arbiter_pkg;

    localparam int GRID_ADDR_W = 14;
    localparam int GRID_DATA_W = 2;
    localparam int GRID_CELLS  = 1 << GRID_ADDR_W;

    typedef enum logic [1:0] {
        CELL_EMPTY    = 2'b00,
        CELL_WALL     = 2'b01,
        CELL_ROBOT    = 2'b10,
        CELL_TREASURE = 2'b11
    } cell_t;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // A single requester still needs a 1-bit pointer so the port list stays legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/grid_write_arbiter_if.sv
// Requester handshake plus grid memory write port owned by grid_write_arbiter.
interface grid_write_arbiter_if
    import grid_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = GRID_ADDR_W,
    parameter int DATA_W  = GRID_DATA_W
);
    logic                      clear_req;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_index;
    logic [NUM_REQ*DATA_W-1:0] req_value;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      w_en;
    logic [ADDR_W-1:0]         w_index;
    logic [DATA_W-1:0]         value;
    logic                      clear_busy;
    logic                      clear_done;

    modport master (
        output clear_req, req_valid, req_index, req_value,
        input  req_ready, w_en, w_index, value, clear_busy, clear_done
    );

    modport slave (
        input  clear_req, req_valid, req_index, req_value,
        output req_ready, w_en, w_index, value, clear_busy, clear_done
    );
endinterface

// File: rtl/grid_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);
    always_comb begin : pick
        logic found;
        int   idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end
endmodule

// File: rtl/grid_write_arbiter.sv
// Sole writer of the grid memory: round-robin requester arbitration plus a full clear sweep.
module grid_write_arbiter
    import grid_write_arbiter_pkg::*;
#(
    parameter int               NUM_REQ        = 3,
    parameter int               ADDR_W         = GRID_ADDR_W,
    parameter int               DATA_W         = GRID_DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_VALUE   = CELL_EMPTY,
    parameter bit               CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    grid_write_arbiter_if.slave bus
);
    localparam int         PTR_W       = ptr_width(NUM_REQ);
    localparam logic [0:0] RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic [0:0]         state;
    logic [ADDR_W-1:0]  cnt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               grant_en;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A clear request steals the cycle so pending requesters simply wait out the sweep.
    assign grant_en      = !reset && (state == ST_IDLE) && !bus.clear_req;
    assign bus.req_ready = grant_en ? grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RESET_STATE;
            cnt            <= '0;
            ptr            <= '0;
            bus.w_en       <= 1'b0;
            bus.w_index    <= '0;
            bus.value      <= '0;
            bus.clear_busy <= 1'b0;
            bus.clear_done <= 1'b0;
        end else begin
            bus.clear_done <= 1'b0;
            bus.clear_busy <= (state == ST_CLEAR);
            if (state == ST_CLEAR) begin
                bus.w_en    <= 1'b1;
                bus.w_index <= cnt;
                bus.value   <= CLEAR_VALUE;
                cnt         <= cnt + 1'b1;
                if (&cnt) begin
                    bus.clear_done <= 1'b1;
                    state          <= ST_IDLE;
                end
            end else if (bus.clear_req) begin
                bus.w_en <= 1'b0;
                state    <= ST_CLEAR;
            end else if (|grant) begin
                bus.w_en    <= 1'b1;
                bus.w_index <= bus.req_index[grant_idx*ADDR_W +: ADDR_W];
                bus.value   <= bus.req_value[grant_idx*DATA_W +: DATA_W];
                ptr         <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end else begin
                bus.w_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_grid_write_arbiter.sv
// Scoreboard bench for grid_write_arbiter: reference model predicts each write-port cycle.
module tb_grid_write_arbiter;
    import grid_write_arbiter_pkg::*;

    localparam int N     = 3;
    localparam int AW    = 14;
    localparam int DW    = 2;
    localparam int CELLS = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grid_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    grid_write_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW),
        .CLEAR_VALUE(CELL_EMPTY), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          w_en;
        logic [AW-1:0] idx;
        logic [DW-1:0] val;
        logic          done;
        logic          busy;
    } rec_t;

    rec_t exp_q[$];
    int   act_grants[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_seen = 0;

    // Reference model: sweeping flag, sweep position, fairness pointer, last written cell.
    bit            m_clear;
    int            m_cnt;
    int            m_ptr;
    logic [AW-1:0] m_widx;
    logic [DW-1:0] m_wval;
    logic [N-1:0]  granted_last;
    int            waits [N];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    rec_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("w_en",       32'(bus.w_en),       32'(mon_e.w_en));
            chk("w_index",    32'(bus.w_index),    32'(mon_e.idx));
            chk("value",      32'(bus.value),      32'(mon_e.val));
            chk("clear_done", 32'(bus.clear_done), 32'(mon_e.done));
            chk("clear_busy", 32'(bus.clear_busy), 32'(mon_e.busy));
            if (bus.clear_done === 1'b1) done_seen++;
        end
    end

    // Predict the coming edge from current inputs, check the grant, then advance one clock.
    task automatic tick();
        logic [N-1:0] er;
        rec_t         r;
        int           g;
        #1;
        er = '0;
        g  = -1;
        r.w_en = 1'b0; r.idx = m_widx; r.val = m_wval; r.done = 1'b0; r.busy = 1'b0;
        if (reset) begin
            r.idx   = '0;
            r.val   = '0;
            m_widx  = '0;
            m_wval  = '0;
            m_clear = 1'b1;
            m_cnt   = 0;
            m_ptr   = 0;
        end else if (m_clear) begin
            r.w_en = 1'b1;
            r.idx  = AW'(m_cnt);
            r.val  = CELL_EMPTY;
            r.busy = 1'b1;
            r.done = (m_cnt == CELLS - 1);
            m_widx = r.idx;
            m_wval = r.val;
            if (m_cnt == CELLS - 1) begin
                m_clear = 1'b0;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end else if (bus.clear_req) begin
            m_clear = 1'b1;
        end else begin
            for (int k = 0; k < N; k++)
                if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) begin
                er[g]  = 1'b1;
                r.w_en = 1'b1;
                r.idx  = bus.req_index[g*AW +: AW];
                r.val  = bus.req_value[g*DW +: DW];
                m_widx = r.idx;
                m_wval = r.val;
                m_ptr  = (g + 1) % N;
            end
        end
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        granted_last = bus.req_ready;
        for (int i = 0; i < N; i++)
            if (bus.req_ready[i]) act_grants.push_back(i);
        @(posedge clk);
        exp_q.push_back(r);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic new_req(input int i);
        bus.req_valid[i]          = 1'b1;
        bus.req_index[i*AW +: AW] = AW'($urandom_range(0, 3) + 32'h40);
        bus.req_value[i*DW +: DW] = DW'($urandom);
    endtask

    initial begin
        m_clear = 1'b1; m_cnt = 0; m_ptr = 0; m_widx = '0; m_wval = '0;
        granted_last = '0;
        reset         = 1'b1;
        bus.clear_req = 1'b0;
        bus.req_valid = '1;
        bus.req_index = '0;
        bus.req_value = '0;
        repeat (3) tick();
        bus.req_valid = '0;
        reset = 1'b0;

        // Power-on sweep with no traffic.
        done_seen = 0;
        repeat (CELLS + 2) tick();
        settle();
        chk("sweep1_done_count", 32'(done_seen), 32'd1);
        chk("sweep1_idle_wen", 32'(bus.w_en), 32'd0);

        // Single requester, one-cycle write latency.
        bus.req_index[0 +: AW] = 14'h0105;
        bus.req_value[0 +: DW] = 2'b01;
        bus.req_valid          = 3'b001;
        tick();
        bus.req_valid = '0;
        chk("t2_w_en",    32'(bus.w_en),    32'd1);
        chk("t2_w_index", 32'(bus.w_index), 32'h0105);
        chk("t2_value",   32'(bus.value),   32'd1);
        new_req(2);
        bus.req_valid = 3'b100;
        tick();
        bus.req_valid = '0;

        // All requesters continuously valid starting from pointer 0.
        act_grants.delete();
        bus.req_valid = '1;
        for (int i = 0; i < N; i++) new_req(i);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t3_w_en_held", 32'(bus.w_en), 32'd1);
            for (int i = 0; i < N; i++) if (granted_last[i]) new_req(i);
        end
        bus.req_valid = '0;
        tick();
        chk("t3_grant_count", 32'(act_grants.size()), 32'd6);
        for (int k = 0; k < 6 && k < act_grants.size(); k++)
            chk("t3_grant_order", 32'(act_grants[k]), 32'(k % N));

        // Clear request collides with pending requests; a second pulse mid-sweep is ignored.
        new_req(1);
        new_req(2);
        bus.req_valid = 3'b110;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        settle();
        act_grants.delete();
        done_seen = 0;
        for (int k = 0; k < CELLS; k++) begin
            bus.clear_req = (k == 100);
            tick();
        end
        bus.clear_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int i = 0; i < N; i++) if (granted_last[i]) bus.req_valid[i] = 1'b0;
        end
        settle();
        chk("t4_done_count", 32'(done_seen), 32'd1);
        chk("t4_grant_count", 32'(act_grants.size()), 32'd2);
        if (act_grants.size() == 2) begin
            chk("t4_first_grant",  32'(act_grants[0]), 32'd1);
            chk("t4_second_grant", 32'(act_grants[1]), 32'd2);
        end

        // Random traffic with colliding indices; no requester waits more than N-1 grants.
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!bus.req_valid[i] && ($urandom_range(0, 2) != 0)) new_req(i);
            tick();
            for (int i = 0; i < N; i++) begin
                if (granted_last[i]) begin
                    chk("fair_wait", 32'(waits[i] <= N - 1), 32'd1);
                    waits[i] = 0;
                    bus.req_valid[i] = 1'b0;
                end else if (bus.req_valid[i] && granted_last != '0) begin
                    waits[i]++;
                end
            end
        end
        bus.req_valid = '0;
        tick();

        // Reset partway through a sweep restarts it from cell 0.
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (5000) tick();
        reset = 1'b1;
        repeat (2) tick();
        settle();
        chk("t6_reset_w_en",    32'(bus.w_en),       32'd0);
        chk("t6_reset_w_index", 32'(bus.w_index),    32'd0);
        chk("t6_reset_busy",    32'(bus.clear_busy), 32'd0);
        reset = 1'b0;
        done_seen = 0;
        tick();
        chk("t6_restart_index", 32'(bus.w_index), 32'd0);
        chk("t6_restart_w_en",  32'(bus.w_en),    32'd1);
        repeat (CELLS + 1) tick();
        settle();
        chk("t6_done_count", 32'(done_seen), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
